// File: rtl/regfile_port_arbiter_pkg.sv
// Shared constants, FSM state and requester ids for the register-file port arbiter.
package regfile_port_arbiter_pkg;

    localparam int RF_AW   = 5;
    localparam int RF_DW   = 32;
    localparam int RF_NREG = 32;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    // Bit positions of each requester in the req/grant vectors
    localparam int REQ_A = 0;
    localparam int REQ_B = 1;

endpackage

// File: rtl/regfile_port_arbiter_if.sv
// Requester, clear-control and register-file signals of the port arbiter.
interface regfile_port_arbiter_if
    import regfile_port_arbiter_pkg::*;
#(
    parameter int AW = RF_AW,
    parameter int DW = RF_DW
);
    logic          req_a;
    logic          we_a;
    logic [AW-1:0] addr_a;
    logic [DW-1:0] wdata_a;
    logic          ack_a;
    logic          rvalid_a;
    logic [DW-1:0] rdata_a;

    logic          req_b;
    logic          we_b;
    logic [AW-1:0] addr_b;
    logic [DW-1:0] wdata_b;
    logic          ack_b;
    logic          rvalid_b;
    logic [DW-1:0] rdata_b;

    logic          clr_start;
    logic          clr_busy;
    logic          clr_done;

    logic          rf_we;
    logic [AW-1:0] rf_addr;
    logic [DW-1:0] rf_wdata;
    logic [DW-1:0] rf_rdata;

    // Arbiter side
    modport slave (
        input  req_a, we_a, addr_a, wdata_a,
        input  req_b, we_b, addr_b, wdata_b,
        input  clr_start, rf_rdata,
        output ack_a, rvalid_a, rdata_a,
        output ack_b, rvalid_b, rdata_b,
        output clr_busy, clr_done,
        output rf_we, rf_addr, rf_wdata
    );

    // Requester / register-file side
    modport master (
        output req_a, we_a, addr_a, wdata_a,
        output req_b, we_b, addr_b, wdata_b,
        output clr_start, rf_rdata,
        input  ack_a, rvalid_a, rdata_a,
        input  ack_b, rvalid_b, rdata_b,
        input  clr_busy, clr_done,
        input  rf_we, rf_addr, rf_wdata
    );

endinterface

// File: rtl/regfile_port_arbiter_rr_arb2.sv
// Two-way round-robin picker: combinational one-hot grant, registered last winner.
module regfile_port_arbiter_rr_arb2
    import regfile_port_arbiter_pkg::*;
(
    input  logic       Clk,
    input  logic       Reset,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    logic last_b;   // 1: B won most recently, so A wins the next tie

    // A lone requester wins outright; a tie goes to whoever did not win last
    always_comb begin
        gnt = req;
        if (req[REQ_A] && req[REQ_B]) begin
            gnt = '0;
            if (last_b)
                gnt[REQ_A] = 1'b1;
            else
                gnt[REQ_B] = 1'b1;
        end
    end

    // Remember the latest winner; held while nothing is granted (e.g. during clear)
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset)
            last_b <= 1'b1;
        else if (gnt[REQ_A])
            last_b <= 1'b0;
        else if (gnt[REQ_B])
            last_b <= 1'b1;
    end

endmodule

// File: rtl/regfile_port_arbiter.sv
// Shares the register-file port between requesters A and B and sequences bulk clear.
// Grant decided in cycle N, access presented to the file in N+1, read data in N+2.
module regfile_port_arbiter
    import regfile_port_arbiter_pkg::*;
#(
    parameter int AW   = RF_AW,
    parameter int DW   = RF_DW,
    parameter int NREG = RF_NREG
) (
    input  logic                  Clk,
    input  logic                  Reset,
    regfile_port_arbiter_if.slave bus
);

    state_t        state, state_nxt;
    logic [AW-1:0] cnt, cnt_nxt;
    logic          arb_en;
    logic [1:0]    elig, gnt;
    logic          last_cnt;

    logic          ack_a, ack_b;
    logic          rvalid_a, rvalid_b;
    logic [DW-1:0] rdata_a, rdata_b;
    logic          clr_done;
    logic          rf_we;
    logic [AW-1:0] rf_addr;
    logic [DW-1:0] rf_wdata;

    assign last_cnt = (cnt == AW'(NREG - 1));

    // A requester whose ack is up this cycle is already being served
    assign elig[REQ_A] = bus.req_a & ~ack_a & arb_en;
    assign elig[REQ_B] = bus.req_b & ~ack_b & arb_en;

    regfile_port_arbiter_rr_arb2 u_arb (
        .Clk   (Clk),
        .Reset (Reset),
        .req   (elig),
        .gnt   (gnt)
    );

    // Next state / clear counter; arbitration only in IDLE with no clear pending
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        arb_en    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.clr_start) begin
                    state_nxt = ST_CLEAR;
                    cnt_nxt   = '0;
                end else begin
                    arb_en = 1'b1;
                end
            end
            ST_CLEAR: begin
                if (last_cnt) begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + AW'(1);
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State and clear counter registers; cnt mirrors rf_addr while clearing
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // File port and ack registers: clear writes take priority over granted accesses
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            ack_a    <= 1'b0;
            ack_b    <= 1'b0;
            clr_done <= 1'b0;
            rf_we    <= 1'b0;
            rf_addr  <= '0;
            rf_wdata <= '0;
        end else begin
            ack_a    <= gnt[REQ_A];
            ack_b    <= gnt[REQ_B];
            clr_done <= (state == ST_CLEAR) && (state_nxt == ST_IDLE);
            if (state_nxt == ST_CLEAR) begin
                rf_we    <= 1'b1;
                rf_addr  <= cnt_nxt;
                rf_wdata <= '0;
            end else if (gnt[REQ_A]) begin
                rf_we    <= bus.we_a;
                rf_addr  <= bus.addr_a;
                rf_wdata <= bus.wdata_a;
            end else if (gnt[REQ_B]) begin
                rf_we    <= bus.we_b;
                rf_addr  <= bus.addr_b;
                rf_wdata <= bus.wdata_b;
            end else begin
                rf_we <= 1'b0;
            end
        end
    end

    // Capture read data during the issue cycle and flag it the cycle after
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            rvalid_a <= 1'b0;
            rvalid_b <= 1'b0;
            rdata_a  <= '0;
            rdata_b  <= '0;
        end else begin
            rvalid_a <= ack_a & ~rf_we;
            rvalid_b <= ack_b & ~rf_we;
            if (ack_a && !rf_we)
                rdata_a <= bus.rf_rdata;
            if (ack_b && !rf_we)
                rdata_b <= bus.rf_rdata;
        end
    end

    assign bus.ack_a    = ack_a;
    assign bus.ack_b    = ack_b;
    assign bus.rvalid_a = rvalid_a;
    assign bus.rvalid_b = rvalid_b;
    assign bus.rdata_a  = rdata_a;
    assign bus.rdata_b  = rdata_b;
    assign bus.clr_busy = (state == ST_CLEAR);
    assign bus.clr_done = clr_done;
    assign bus.rf_we    = rf_we;
    assign bus.rf_addr  = rf_addr;
    assign bus.rf_wdata = rf_wdata;

endmodule

// File: tb/tb_regfile_port_arbiter.sv
// Self-checking bench: directed scenarios with literal expectations plus a random
// phase, all checked every cycle against a transaction-level reference model.
module tb_regfile_port_arbiter;
    import regfile_port_arbiter_pkg::*;

    logic Clk   = 1'b0;
    logic Reset = 1'b1;
    int   total = 0;
    int   bad   = 0;
    bit   chk_en = 1'b0;

    regfile_port_arbiter_if #(.AW(RF_AW), .DW(RF_DW)) bus ();

    regfile_port_arbiter #(.AW(RF_AW), .DW(RF_DW), .NREG(RF_NREG)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 Clk = ~Clk;

    // Register file: combinational read, write on the clock edge
    logic [31:0] rf_mem [2**RF_AW] = '{default: '0};
    assign bus.rf_rdata = rf_mem[bus.rf_addr];
    always @(posedge Clk) if (bus.rf_we) rf_mem[bus.rf_addr] <= bus.rf_wdata;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        chk(nm, 32'(act), 32'(exp));
    endtask

    // ---------------- reference model ----------------
    // m_* are what the outputs must show in the current cycle.
    logic        m_ack_a = 0, m_ack_b = 0, m_rv_a = 0, m_rv_b = 0;
    logic        m_we = 0, m_busy = 0, m_done = 0;
    logic [31:0] m_rd_a = 0, m_rd_b = 0, m_wd = 0;
    int          m_addr = 0, m_cnt = 0, m_last = 1;   // m_last: 0=A, 1=B
    logic [31:0] ref_mem [2**RF_AW] = '{default: '0};

    task automatic model_reset();
        m_ack_a = 0; m_ack_b = 0; m_rv_a = 0; m_rv_b = 0;
        m_we = 0; m_busy = 0; m_done = 0;
        m_rd_a = 0; m_rd_b = 0; m_wd = 0;
        m_addr = 0; m_cnt = 0; m_last = 1;
    endtask

    task automatic model_step();
        bit rd_a, rd_b, ea, eb;
        int win;
        // what was presented this cycle takes effect at this edge
        rd_a = m_ack_a && !m_we;
        rd_b = m_ack_b && !m_we;
        if (rd_a) m_rd_a = ref_mem[m_addr];
        if (rd_b) m_rd_b = ref_mem[m_addr];
        m_rv_a = rd_a;
        m_rv_b = rd_b;
        if (m_we) ref_mem[m_addr] = m_wd;
        ea = bus.req_a && !m_ack_a;
        eb = bus.req_b && !m_ack_b;
        m_ack_a = 0; m_ack_b = 0; m_we = 0; m_done = 0; win = -1;
        if (m_busy) begin
            if (m_cnt == RF_NREG - 1) begin
                m_busy = 0; m_done = 1; m_cnt = 0;
            end else begin
                m_cnt++; m_we = 1; m_addr = m_cnt; m_wd = 0;
            end
        end else if (bus.clr_start) begin
            m_busy = 1; m_cnt = 0; m_we = 1; m_addr = 0; m_wd = 0;
        end else begin
            if (ea && eb) win = (m_last == 0) ? 1 : 0;
            else if (ea)  win = 0;
            else if (eb)  win = 1;
            if (win == 0) begin
                m_ack_a = 1; m_we = bus.we_a; m_addr = int'(bus.addr_a); m_wd = bus.wdata_a; m_last = 0;
            end else if (win == 1) begin
                m_ack_b = 1; m_we = bus.we_b; m_addr = int'(bus.addr_b); m_wd = bus.wdata_b; m_last = 1;
            end
        end
    endtask

    initial forever begin
        @(posedge Clk or posedge Reset);
        if (Reset) model_reset();
        else       model_step();
    end

    // Compare every output against the model, away from the active edge
    initial forever begin
        @(negedge Clk);
        if (chk_en && !Reset) begin
            chk1("ack_a", bus.ack_a, m_ack_a);
            chk1("ack_b", bus.ack_b, m_ack_b);
            chk1("ack_excl", bus.ack_a & bus.ack_b, 1'b0);
            chk1("rvalid_a", bus.rvalid_a, m_rv_a);
            chk1("rvalid_b", bus.rvalid_b, m_rv_b);
            chk("rdata_a", bus.rdata_a, m_rd_a);
            chk("rdata_b", bus.rdata_b, m_rd_b);
            chk1("clr_busy", bus.clr_busy, m_busy);
            chk1("clr_done", bus.clr_done, m_done);
            chk1("rf_we", bus.rf_we, m_we);
            chk("rf_addr", 32'(bus.rf_addr), 32'(m_addr));
            if (m_we) chk("rf_wdata", bus.rf_wdata, m_wd);
        end
    end

    // ---------------- directed helpers ----------------
    task automatic access(input bit isb, input bit we, input logic [4:0] addr,
                          input logic [31:0] data, input logic [31:0] exp, input string tag);
        @(negedge Clk);
        if (isb) begin bus.req_b = 1; bus.we_b = we; bus.addr_b = addr; bus.wdata_b = data; end
        else     begin bus.req_a = 1; bus.we_a = we; bus.addr_a = addr; bus.wdata_a = data; end
        @(negedge Clk);
        chk1({tag, "_ack"}, isb ? bus.ack_b : bus.ack_a, 1'b1);
        chk1({tag, "_we"}, bus.rf_we, we);
        chk({tag, "_addr"}, 32'(bus.rf_addr), 32'(addr));
        bus.req_a = 0;
        bus.req_b = 0;
        if (!we) begin
            @(negedge Clk);
            chk1({tag, "_rvalid"}, isb ? bus.rvalid_b : bus.rvalid_a, 1'b1);
            chk({tag, "_rdata"}, isb ? bus.rdata_b : bus.rdata_a, exp);
        end
    endtask

    task automatic run_clear(input int repulse_at, input bit with_b, input string tag);
        int busy_n = 0;
        int done_n = 0;
        bit b_acked = 0;
        bit b_rv = 0;
        @(negedge Clk);
        bus.clr_start = 1;
        if (with_b) begin bus.req_b = 1; bus.we_b = 0; bus.addr_b = 5; bus.wdata_b = 0; end
        for (int i = 0; i < 45; i++) begin
            @(negedge Clk);
            bus.clr_start = 0;
            if (bus.clr_busy) begin
                chk({tag, "_cl_addr"}, 32'(bus.rf_addr), 32'(busy_n));
                chk1({tag, "_cl_we"}, bus.rf_we, 1'b1);
                chk({tag, "_cl_wdata"}, bus.rf_wdata, 32'h0);
                if (busy_n == repulse_at) bus.clr_start = 1;
                busy_n++;
            end
            if (bus.clr_done) done_n++;
            if (bus.ack_b) begin
                chk({tag, "_ackb_after_done"}, 32'(done_n), 32'd1);
                bus.req_b = 0;
                b_acked = 1;
            end
            if (with_b && bus.rvalid_b) begin
                chk({tag, "_b_rdata"}, bus.rdata_b, 32'h0);
                b_rv = 1;
            end
        end
        chk({tag, "_busy_cycles"}, 32'(busy_n), 32'd32);
        chk({tag, "_done_pulses"}, 32'(done_n), 32'd1);
        if (with_b) begin
            chk1({tag, "_b_acked"}, b_acked, 1'b1);
            chk1({tag, "_b_rvalid"}, b_rv, 1'b1);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int prev;
        int cur;
        bus.req_a = 0; bus.we_a = 0; bus.addr_a = 0; bus.wdata_a = 0;
        bus.req_b = 0; bus.we_b = 0; bus.addr_b = 0; bus.wdata_b = 0;
        bus.clr_start = 0;

        // reset state
        #12;
        chk1("rst_ack_a", bus.ack_a, 1'b0);
        chk1("rst_ack_b", bus.ack_b, 1'b0);
        chk1("rst_rf_we", bus.rf_we, 1'b0);
        chk("rst_rf_addr", 32'(bus.rf_addr), 32'h0);
        chk1("rst_busy", bus.clr_busy, 1'b0);
        chk1("rst_done", bus.clr_done, 1'b0);
        chk("rst_rdata_a", bus.rdata_a, 32'h0);
        @(negedge Clk);
        Reset = 0;
        chk_en = 1;

        // A alone: write then read back
        access(0, 1, 5'd3, 32'h1234_5678, 32'h0, "a_wr3");
        access(0, 0, 5'd3, 32'h0, 32'h1234_5678, "a_rd3");

        // A holding its request: served every other cycle
        @(negedge Clk);
        bus.req_a = 1; bus.we_a = 0; bus.addr_a = 3;
        for (int i = 0; i < 8; i++) begin
            @(negedge Clk);
            chk1("solo_ack_a", bus.ack_a, (i % 2) == 0);
            if (i == 7) bus.req_a = 0;
        end

        // make B the latest winner so A takes the next tie
        access(1, 1, 5'd9, 32'h0000_ABCD, 32'h0, "b_wr9");

        // tie: A writes 31, B reads 31 right after and sees the new data
        @(negedge Clk);
        bus.req_a = 1; bus.we_a = 1; bus.addr_a = 31; bus.wdata_a = 32'h7FFF_FFFF;
        bus.req_b = 1; bus.we_b = 0; bus.addr_b = 31;
        @(negedge Clk);
        chk1("tie_ack_a", bus.ack_a, 1'b1);
        chk1("tie_ack_b0", bus.ack_b, 1'b0);
        bus.req_a = 0;
        @(negedge Clk);
        chk1("tie_ack_b", bus.ack_b, 1'b1);
        chk("tie_b_addr", 32'(bus.rf_addr), 32'd31);
        bus.req_b = 0;
        @(negedge Clk);
        chk1("raw_rvalid_b", bus.rvalid_b, 1'b1);
        chk("raw_rdata_b", bus.rdata_b, 32'h7FFF_FFFF);

        // both requesting continuously: grants alternate A,B,A,B
        @(negedge Clk);
        bus.req_a = 1; bus.we_a = 1; bus.addr_a = 5'($urandom_range(0, 31)); bus.wdata_a = $urandom;
        bus.req_b = 1; bus.we_b = 0; bus.addr_b = 5'($urandom_range(0, 31));
        prev = 1;
        for (int i = 0; i < 16; i++) begin
            @(negedge Clk);
            cur = bus.ack_a ? 0 : (bus.ack_b ? 1 : -1);
            chk("alt_grant", 32'(cur), 32'(1 - prev));
            prev = cur;
            if (bus.ack_a) begin
                bus.we_a = 1'($urandom_range(0, 1)); bus.addr_a = 5'($urandom_range(0, 31)); bus.wdata_a = $urandom;
            end
            if (bus.ack_b) begin
                bus.we_b = 1'($urandom_range(0, 1)); bus.addr_b = 5'($urandom_range(0, 31)); bus.wdata_b = $urandom;
            end
        end
        bus.req_a = 0;
        bus.req_b = 0;
        repeat (3) @(negedge Clk);

        // clear after seeding 0, 5 and 31
        access(0, 1, 5'd0, 32'h1001_0000, 32'h0, "seed0");
        access(0, 1, 5'd5, 32'h1001_0000, 32'h0, "seed5");
        access(0, 1, 5'd31, 32'h1001_0000, 32'h0, "seed31");
        run_clear(-1, 0, "clr");
        access(0, 0, 5'd0, 32'h0, 32'h0, "clr_rd0");
        access(0, 0, 5'd5, 32'h0, 32'h0, "clr_rd5");
        access(0, 0, 5'd31, 32'h0, 32'h0, "clr_rd31");

        // B requesting with clr_start; then clr_start re-pulsed mid-clear
        access(0, 1, 5'd5, 32'h5555_AAAA, 32'h0, "seed5b");
        run_clear(-1, 1, "clrb");
        run_clear(7, 0, "clr7");

        // reset in the middle of a clear
        @(negedge Clk);
        bus.clr_start = 1;
        @(negedge Clk);
        bus.clr_start = 0;
        repeat (10) @(negedge Clk);
        chk("pre_rst_addr", 32'(bus.rf_addr), 32'd10);
        #2 Reset = 1;
        #1;
        chk1("mid_rst_we", bus.rf_we, 1'b0);
        chk("mid_rst_addr", 32'(bus.rf_addr), 32'h0);
        chk1("mid_rst_busy", bus.clr_busy, 1'b0);
        chk1("mid_rst_ack_a", bus.ack_a, 1'b0);
        chk("mid_rst_rdata_a", bus.rdata_a, 32'h0);
        @(negedge Clk);
        Reset = 0;
        @(negedge Clk);
        chk1("post_rst_busy", bus.clr_busy, 1'b0);
        chk1("post_rst_we", bus.rf_we, 1'b0);
        access(0, 1, 5'd7, 32'hCAFE_0007, 32'h0, "post_wr7");
        access(1, 0, 5'd7, 32'h0, 32'hCAFE_0007, "post_rd7");

        // random traffic with occasional clears, checked by the model
        for (int c = 0; c < 3000; c++) begin
            @(negedge Clk);
            if (bus.ack_a || !bus.req_a) begin
                bus.req_a = ($urandom_range(0, 2) != 0);
                bus.we_a = 1'($urandom_range(0, 1));
                bus.addr_a = 5'($urandom_range(0, 31));
                bus.wdata_a = $urandom;
            end
            if (bus.ack_b || !bus.req_b) begin
                bus.req_b = ($urandom_range(0, 2) != 0);
                bus.we_b = 1'($urandom_range(0, 1));
                bus.addr_b = 5'($urandom_range(0, 31));
                bus.wdata_b = $urandom;
            end
            bus.clr_start = ($urandom_range(0, 199) == 0);
        end
        bus.req_a = 0;
        bus.req_b = 0;
        bus.clr_start = 0;
        repeat (40) @(negedge Clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
